// File: rtl/multi_delay_pkg.sv
// Shared types and default constants for the multi-channel delay timer.
package multi_delay_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chan_state_e;

  typedef enum logic {
    ONESHOT  = 1'b0,
    PERIODIC = 1'b1
  } chan_mode_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CBITS  = 15;
  localparam int DEF_LIMIT  = 22500;

endpackage

// File: rtl/multi_delay_if.sv
// Control/status bundle for multi_delay: per-channel start/stop, cfg write port, status vectors.
interface multi_delay_if
  import multi_delay_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CBITS  = DEF_CBITS
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] stop;
  logic              cfg_we;
  logic [CHW-1:0]    cfg_ch;
  logic [CBITS-1:0]  cfg_limit;
  logic              cfg_mode;
  logic [NUM_CH-1:0] sig;
  logic [NUM_CH-1:0] flg;
  logic [NUM_CH-1:0] err;
  logic [NUM_CH-1:0] busy;

  modport master (output start, stop, cfg_we, cfg_ch, cfg_limit, cfg_mode,
                  input  sig, flg, err, busy);
  modport slave  (input  start, stop, cfg_we, cfg_ch, cfg_limit, cfg_mode,
                  output sig, flg, err, busy);
endinterface

// File: rtl/multi_delay_chan.sv
// One delay channel: IDLE/RUN/DONE timer with shadowed limit/mode.
// MULTI_DELAY_ERR_EN adds a sticky cnt > lim_a overrun monitor; otherwise err is tied low.
module delay_chan
  import multi_delay_pkg::*;
#(
  parameter int CBITS = DEF_CBITS,
  parameter int N_DEF = DEF_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_we,
  input  logic [CBITS-1:0] cfg_limit,
  input  logic             cfg_mode,
  output logic             sig,
  output logic             flg,
  output logic             err,
  output logic             busy
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;
  localparam logic [CBITS-1:0] LIM_RST = CBITS'(N_DEF);

  logic [1:0]       state_q, state_d;
  logic [CBITS-1:0] cnt_q, cnt_d, lim_a_q, lim_a_d, lim_s_q, lim_s_d;
  logic             mode_a_q, mode_a_d, mode_s_q, mode_s_d;
  logic             sig_q, sig_d, flg_q, flg_d, busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lim_a_d  = lim_a_q;
    mode_a_d = mode_a_q;
    lim_s_d  = lim_s_q;
    mode_s_d = mode_s_q;
    sig_d    = 1'b0;
    if (cfg_we) begin
      lim_s_d  = cfg_limit;
      mode_s_d = cfg_mode;
    end
    // Active values only ever load from the pre-write shadow, so a same-cycle cfg write waits a period.
    if (stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      if (cnt_q == lim_a_q) begin
        sig_d = 1'b1;
        if (mode_a_q == PERIODIC) begin
          cnt_d    = '0;
          lim_a_d  = lim_s_q;
          mode_a_d = mode_s_q;
        end else begin
          state_d = S_DONE;
        end
      end else if (cnt_q < lim_a_q) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (start) begin
      state_d  = S_RUN;
      cnt_d    = '0;
      lim_a_d  = lim_s_q;
      mode_a_d = mode_s_q;
    end
    busy_d = (state_d == S_RUN);
    flg_d  = busy_d && (cnt_d <= lim_a_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lim_a_q  <= LIM_RST;
      lim_s_q  <= LIM_RST;
      mode_a_q <= PERIODIC;
      mode_s_q <= PERIODIC;
      sig_q    <= 1'b0;
      flg_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lim_a_q  <= lim_a_d;
      lim_s_q  <= lim_s_d;
      mode_a_q <= mode_a_d;
      mode_s_q <= mode_s_d;
      sig_q    <= sig_d;
      flg_q    <= flg_d;
      busy_q   <= busy_d;
    end
  end

  assign sig  = sig_q;
  assign flg  = flg_q;
  assign busy = busy_q;

`ifdef MULTI_DELAY_ERR_EN
  logic err_q, err_d;
  always_comb err_d = err_q | (cnt_q > lim_a_q);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/multi_delay.sv
// NUM_CH independent delay channels sharing one cfg write port.
// Define MULTI_DELAY_ERR_EN to enable the per-channel overrun monitor on err.
module multi_delay
  import multi_delay_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CBITS  = DEF_CBITS,
  parameter int N_DEF  = DEF_LIMIT
) (
  input  logic          clk,
  input  logic          rst,
  multi_delay_if.slave  bus
);
  logic [NUM_CH-1:0] we_v, sig_v, flg_v, err_v, busy_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range cfg_ch matches no channel and is dropped.
    assign we_v[i] = bus.cfg_we && (int'(bus.cfg_ch) == i);

    delay_chan #(.CBITS(CBITS), .N_DEF(N_DEF)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .start    (bus.start[i]),
      .stop     (bus.stop[i]),
      .cfg_we   (we_v[i]),
      .cfg_limit(bus.cfg_limit),
      .cfg_mode (bus.cfg_mode),
      .sig      (sig_v[i]),
      .flg      (flg_v[i]),
      .err      (err_v[i]),
      .busy     (busy_v[i])
    );
  end

  assign bus.sig  = sig_v;
  assign bus.flg  = flg_v;
  assign bus.err  = err_v;
  assign bus.busy = busy_v;

endmodule

// File: doc/multi_delay.md
MULTI_DELAY -- requirements
Module: multi_delay

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent delay channels (1..16).
REQ-002 Parameter CBITS, default 15, counter and limit width per channel.
REQ-003 Parameter N_DEF, default 22500, reset value of every channel's limit register (must fit in CBITS).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-006 start  input  NUM_CH  per-channel start request, level sampled each cycle.
REQ-007 stop  input  NUM_CH  per-channel stop request, level sampled each cycle.
REQ-008 cfg_we  input  1  write strobe for channel configuration.
REQ-009 cfg_ch  input  $clog2(NUM_CH) (min 1)  channel index for cfg write.
REQ-010 cfg_limit  input  CBITS  new limit value.
REQ-011 cfg_mode  input  1  0 = one-shot, 1 = periodic.
REQ-012 sig  output  NUM_CH  one-cycle expiry pulse per channel, registered.
REQ-013 flg  output  NUM_CH  channel running with count in range, registered.
REQ-014 err  output  NUM_CH  sticky overrun flag, registered (see REQ-031).
REQ-015 busy  output  NUM_CH  channel in RUN state, registered.

Function
REQ-016 Each channel SHALL have states IDLE, RUN, DONE plus a CBITS counter cnt, active limit lim_a, active mode mode_a, and shadow copies lim_s, mode_s.
REQ-017 cfg_we SHALL write cfg_limit/cfg_mode into lim_s/mode_s of channel cfg_ch; cfg_ch >= NUM_CH SHALL be ignored.
REQ-018 Shadow values SHALL be copied to lim_a/mode_a on IDLE/DONE->RUN transitions and on each periodic reload; a RUN channel never sees a mid-period limit change.
REQ-019 IDLE or DONE with start=1 and stop=0 SHALL go to RUN with cnt=0 next cycle.
REQ-020 In RUN, cnt SHALL increment by 1 per cycle while cnt < lim_a.
REQ-021 In RUN with cnt == lim_a: sig SHALL be 1 the next cycle for exactly one cycle; periodic -> cnt=0, stay RUN; one-shot -> DONE, cnt held.
REQ-022 Expiry period SHALL be lim_a+1 cycles from RUN entry; lim_a=0 in periodic mode SHALL give sig=1 every cycle.
REQ-023 stop=1 SHALL force IDLE and cnt=0 next cycle from any state; stop wins over start and over expiry (no sig that cycle).
REQ-024 start=1 while already RUN SHALL be ignored (no restart).
REQ-025 flg SHALL be 1 iff state is RUN and cnt <= lim_a.
REQ-026 busy SHALL be 1 iff state is RUN.
REQ-027 cnt SHALL never wrap; lim_a = 2^CBITS-1 is a legal limit.
REQ-028 Channels SHALL be fully independent; simultaneous events on different channels all take effect in the same cycle.
REQ-029 cfg write to a channel in the same cycle it starts SHALL be captured in the shadow only; the start uses the prior shadow value.

Reset
REQ-030 On rst low: all channels IDLE, cnt=0, lim_a=lim_s=N_DEF, mode_a=mode_s=1, sig=flg=err=busy=0; effect immediate, release synchronous to next clk edge.

Configuration
REQ-031 Macro MULTI_DELAY_ERR_EN defined: err[i] SHALL set when cnt > lim_a in channel i and stay set until reset (safety monitor, unreachable in correct design).
REQ-032 MULTI_DELAY_ERR_EN undefined: err SHALL be tied to 0 and no comparator logic SHALL be synthesised.

Structure
REQ-033 Package multi_delay_pkg SHALL hold the channel state enum (IDLE/RUN/DONE), mode enum (ONESHOT/PERIODIC) and default constants.
REQ-034 Sub-module delay_chan SHALL implement one channel; multi_delay SHALL instantiate NUM_CH copies via generate and decode cfg writes.

Verification
REQ-035 Reset, write ch0 limit 3 periodic, start ch0 one cycle -> sig[0] pulses every 4 cycles, flg[0]=1, busy[0]=1.
REQ-036 ch1 limit 5 one-shot, start -> single sig[1] 6 cycles after start, then DONE, busy[1]=0; restart -> second pulse after 6 more cycles.
REQ-037 ch0 running limit 3, write limit 7 mid-period -> current period stays 4 cycles, following periods 8 cycles.
REQ-038 start and stop high together on ch2; stop asserted in the cycle cnt==lim_a -> ch2 IDLE, no sig[2].
REQ-039 ch3 periodic limit 0 -> sig[3]=1 every cycle; rst pulsed low mid-run -> all outputs 0 immediately, limits back to 22500.
REQ-040 With MULTI_DELAY_ERR_EN defined, random start/stop/cfg for 10000 cycles -> err stays 0 on all channels.
